mac_array_seq: RTL and testbench

Sequencer for the chained `mac_col_c` array.
- Drives the single activation/key SRAM read port and the 2-bit `inst` bus into column 0.
- Runs one attention pass per `start` pulse: load key vectors into every column, then stream query vectors for execution, then drain the column pipeline.
- Stalls query issue while the output FIFO is full.
- Sits between the top-level core controller and the `mac_array` instance.

---
 rtl/mac_array_seq.sv | 112 +++++++++++
 tb/tb_mac_array_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// Sequencer for the chained MAC column array: loads key vectors, streams queries
// under output-FIFO backpressure, then drains the column pipeline once per start.
module mac_array_seq #(
    parameter int col    = 8,
    parameter int addr_w = 5,
    parameter int n_q    = 8,
    parameter int q_base = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_ready,
    input  logic              ofifo_full,
    output logic              sram_cen,
    output logic [addr_w-1:0] sram_addr,
    output logic [1:0]        inst,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_RDY = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] GAP      = 3'd3;
    localparam logic [2:0] EXEC     = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;
    localparam logic [2:0] FIN      = 3'd6;

    localparam int cnt_w = $clog2(col + n_q + 3);

    localparam logic [cnt_w-1:0]  load_last  = cnt_w'(col + 1);
    localparam logic [cnt_w-1:0]  exec_last  = cnt_w'(n_q - 1);
    localparam logic [cnt_w-1:0]  drain_last = cnt_w'(col + 1);
    localparam logic [cnt_w-1:0]  cnt_one    = cnt_w'(1);
    localparam logic [addr_w-1:0] addr_one   = addr_w'(1);
    localparam logic [addr_w-1:0] q_addr0    = addr_w'(q_base);

    logic [2:0]       state;
    logic [cnt_w-1:0] cnt;
    logic             load_rd;
    logic             exec_rd;

    // Reads are decoded from state so an asynchronous reset silences the SRAM at once.
    always_comb begin
        load_rd  = (state == LOAD);
        exec_rd  = (state == EXEC) && !ofifo_full;
        sram_cen = !(load_rd || exec_rd);
        busy     = (state != IDLE) && (state != FIN);
        done     = (state == FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sram_addr <= '0;
            inst      <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            // inst trails the read by one cycle to match the SRAM read latency.
            inst <= {exec_rd, load_rd};
            case (state)
                IDLE: begin
                    if (start) state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (load_ready) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        sram_addr <= '0;
                    end
                end
                LOAD: begin
                    if (cnt == load_last) begin
                        state     <= GAP;
                        cnt       <= '0;
                        sram_addr <= q_addr0;
                    end else begin
                        cnt       <= cnt + cnt_one;
                        sram_addr <= sram_addr + addr_one;
                    end
                end
                GAP: begin
                    state <= EXEC;
                    cnt   <= '0;
                end
                EXEC: begin
                    if (!ofifo_full) begin
                        sram_addr <= sram_addr + addr_one;
                        if (cnt == exec_last) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + cnt_one;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == drain_last) begin
                        state <= FIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_one;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Self-checking bench for mac_array_seq: each pass is expanded into an expected
// per-cycle trace from the pass description (wait length, stalls per query).
module tb_mac_array_seq;

    localparam int col    = 8;
    localparam int addr_w = 5;
    localparam int n_q    = 8;
    localparam int q_base = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load_ready;
    logic              ofifo_full;
    logic              sram_cen;
    logic [addr_w-1:0] sram_addr;
    logic [1:0]        inst;
    logic              busy;
    logic              done;

    mac_array_seq #(.col(col), .addr_w(addr_w), .n_q(n_q), .q_base(q_base)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_ready (load_ready),
        .ofifo_full (ofifo_full),
        .sram_cen   (sram_cen),
        .sram_addr  (sram_addr),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lr;
        logic       full;
        logic       cen;
        int         addr;
        logic [1:0] inst;
        logic       busy;
        logic       done;
    } cyc_t;

    cyc_t tr[$];
    int   stalls[n_q];
    int   prev_kind;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".cen"},  sram_cen, 1);
        check({tag, ".inst"}, inst, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
    endtask

    // kind: 0 = no read, 1 = key load read, 2 = query read
    task automatic push(input logic lr, input logic full, input int kind, input int addr,
                        input logic fin);
        cyc_t c;
        c.lr   = lr;
        c.full = full;
        c.cen  = (kind == 0);
        c.addr = addr;
        c.inst = (prev_kind == 1) ? 2'b01 : (prev_kind == 2) ? 2'b10 : 2'b00;
        c.busy = !fin;
        c.done = fin;
        prev_kind = kind;
        tr.push_back(c);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic build(input int w);
        tr.delete();
        prev_kind = 0;
        for (int i = 0; i < w; i++) push(1'b0, rnd(), 0, 0, 1'b0);
        push(1'b1, rnd(), 0, 0, 1'b0);
        for (int i = 0; i < col + 2; i++) push(rnd(), rnd(), 1, i, 1'b0);
        push(rnd(), rnd(), 0, 0, 1'b0);
        for (int q = 0; q < n_q; q++) begin
            for (int s = 0; s < stalls[q]; s++) push(rnd(), 1'b1, 0, 0, 1'b0);
            push(rnd(), 1'b0, 2, q_base + q, 1'b0);
        end
        for (int i = 0; i < col + 2; i++) push(rnd(), rnd(), 0, 0, 1'b0);
        push(rnd(), rnd(), 0, 0, 1'b1);
    endtask

    // Called just after a rising edge with the DUT in IDLE.
    task automatic run_pass(input string tag, input int w);
        build(w);
        #1 start = 1'b1; load_ready = rnd(); ofifo_full = rnd();
        #1 idle_check({tag, ".pre"});
        @(posedge clk);
        foreach (tr[i]) begin
            #1;
            start      = rnd();
            load_ready = tr[i].lr;
            ofifo_full = tr[i].full;
            #1;
            check($sformatf("%s.c%0d.cen", tag, i),  sram_cen, tr[i].cen);
            check($sformatf("%s.c%0d.inst", tag, i), inst, tr[i].inst);
            check($sformatf("%s.c%0d.busy", tag, i), busy, tr[i].busy);
            check($sformatf("%s.c%0d.done", tag, i), done, tr[i].done);
            if (!tr[i].cen)
                check($sformatf("%s.c%0d.addr", tag, i), sram_addr, tr[i].addr);
            @(posedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            #1 start = 1'b0; load_ready = rnd(); ofifo_full = rnd();
            #1 idle_check($sformatf("%s.post%0d", tag, i));
            @(posedge clk);
        end
    endtask

    task automatic clear_stalls();
        for (int q = 0; q < n_q; q++) stalls[q] = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_ready = 1'b0; ofifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 idle_check("in_reset");
        check("in_reset.addr", sram_addr, 0);
        reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            #1 load_ready = rnd(); ofifo_full = rnd();
            #1 idle_check($sformatf("idle%0d", i));
            @(posedge clk);
        end

        clear_stalls();
        run_pass("nominal", 0);
        run_pass("late_rdy", 5);
        stalls[3] = 3;
        run_pass("backpressure", 0);
        clear_stalls();
        stalls[n_q-1] = 1;
        run_pass("last_slot_stall", 1);

        // Reset lands mid-LOAD while address 4 is being read.
        clear_stalls();
        #1 start = 1'b1; load_ready = 1'b1; ofifo_full = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst.pre_addr", sram_addr, 4);
        check("midrst.pre_cen", sram_cen, 0);
        #1 reset = 1'b1;
        #1 idle_check("midrst");
        check("midrst.addr", sram_addr, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        run_pass("after_rst", 2);

        for (int p = 0; p < 6; p++) begin
            for (int q = 0; q < n_q; q++)
                stalls[q] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_pass($sformatf("rand%0d", p), int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
